cycle_sequencer: RTL and testbench
==================================

# cycle_sequencer

Parametrised instruction-cycle sequencer for the TB4004 core, and the successor to the fixed 8-cycle counter. It drives a configurable-length cycle frame (A1..X3 for the 4004 build). It adds a SYNC pulse at a configurable position, a one-hot phase bus, and halt and single-step control at instruction-frame boundaries. It also counts retired instruction frames for debug. It sits directly after the toggle clock divider and feeds every cycle-qualified block (address out, ROM/RAM bus, decoder, ALU).

## Interface
- NUM_CYCLES, default 8: cycles per instruction frame; must be ≥ 2.
- CW, default $clog2(NUM_CYCLES): width of the cycle index.
- SYNC_CYCLE, default 7: cycle index at which sync is asserted; must be in 0..NUM_CYCLES-1.
- ICNT_W, default 16: width of the frame counter.
- START_HALTED, default 0: when 1, reset enters STOPPED instead of RUN.

Ports:
- toggle_clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- halt_req  in  1  level: request to stop at the next frame boundary, or to stay stopped.
- step  in  1  single-cycle pulse: execute exactly one frame while STOPPED.
- cycle  out  CW  current cycle index, 0..NUM_CYCLES-1.
- phase  out  NUM_CYCLES  one-hot decode of cycle; all zero when STOPPED.
- sync  out  1  high while cycle==SYNC_CYCLE and state≠STOPPED.
- frame_end  out  1  high during the last cycle (NUM_CYCLES-1) of a frame that is executing.
- halted  out  1  high while state==STOPPED.
- instr_count  out  ICNT_W  number of completed frames, modulo 2^ICNT_W.

## Operation
The sequencer has three states: RUN, STEP and STOPPED.

- **RUN**
  - cycle increments every clock and wraps from NUM_CYCLES-1 to 0.
  - At cycle==NUM_CYCLES-1: if halt_req=1, next state is STOPPED; otherwise RUN continues.
  - halt_req is sampled only at the frame's last cycle. A pulse that deasserts before then is ignored.
- **STEP**
  - Behaves exactly like RUN for one frame.
  - At cycle==NUM_CYCLES-1, next state is always STOPPED, regardless of halt_req.
- **STOPPED**
  - cycle holds at 0. phase, sync and frame_end are 0. halted is 1.
  - halt_req=0: next state is RUN, and cycle stays 0 on that edge.
  - halt_req=1 with step=1: next state is STEP, and cycle stays 0 on that edge.
  - If halt_req=0 and step=1 in the same cycle, RUN wins and the step is dropped.
- **Ignored inputs.** step is ignored in RUN and STEP. A step pulse is not queued.
- **Frame counter.** instr_count increments on every edge where frame_end=1, in both RUN and STEP. It wraps from 2^ICNT_W-1 to 0.
- **Output decoding.**
  - sync, phase, frame_end and halted are combinational decodes of the registered cycle and state. No extra latency.
- **Reset.** When rst=1 at an edge:
  - cycle=0 and instr_count=0.
  - state=RUN, or STOPPED if START_HALTED=1.
  - Reset overrides halt_req and step.
  - Reset asserted mid-frame abandons the frame and does not count it.

## Timing
- **Reset values after the reset edge:**
  - cycle=0, instr_count=0.
  - halted = START_HALTED.
  - phase = 1 if running, otherwise 0.
  - sync = 1 only if SYNC_CYCLE==0 and running.
  - frame_end = 0.
- **Resume latency.** halt_req falls while STOPPED: RUN one edge later with cycle=0. cycle=1 follows on the next edge.
- **Halt latency.** halt_req is sampled at the last cycle of the frame. STOPPED is entered on the following edge, so the frame always completes.
- **Step frame.** From the STOPPED→STEP edge, NUM_CYCLES clocks elapse until the return to STOPPED. The step produces exactly one sync and one frame_end.
- **Counter timing.** instr_count updates on the same edge at which cycle wraps to 0.

## Structure
- Shared package tb4004_pkg holds:
  - the state encoding (RUN, STEP, STOPPED);
  - the 4004 defaults NUM_CYCLES=8 and SYNC_CYCLE=7;
  - named cycle constants A1=0, A2, A3, M1, M2, X1, X2, X3=7.
- One natural sub-module: cycle_decoder, which maps cycle and state to phase, sync and frame_end. It is purely combinational.
- The top level holds the counter, the FSM and instr_count.
- Elaboration-time assertions on the parameter ranges.

## Test plan
All scenarios use NUM_CYCLES=8, SYNC_CYCLE=7, ICNT_W=4, START_HALTED=0.

- **Free run.** Reset, then 20 clocks → cycle sequence 0..7,0..7,0..3. sync and frame_end high at cycles 7 only. instr_count=2.
- **Halt at boundary.** Raise halt_req at cycle 3 → cycle continues 4..7, then holds at 0. halted=1 from the next edge. instr_count increments once.
- **Single step.** While STOPPED with halt_req=1, pulse step → exactly 8 cycles 0..7, one sync, instr_count+1, then halted=1. A second step pulse during the frame has no effect.
- **Step/resume collision.** While STOPPED, drive halt_req=0 and step=1 in the same cycle → RUN. Continuous frames follow with no return to STOPPED.
- **Counter wrap.** Run 16 frames → instr_count returns to 0 on the 16th frame_end edge.
- **Reset mid-frame.** Assert rst at cycle 5 → next edge cycle=0 and instr_count=0, with no frame_end. Repeat with START_HALTED=1 → halted=1 and phase=0 after reset.

Source files
------------

// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the TB4004 instruction-cycle sequencer: state encoding,
// 4004 frame defaults and named cycle indices.
package tb4004_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STEP    = 2'd1,
    ST_STOPPED = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_CYCLES = 8;
  localparam int DEF_SYNC_CYCLE = 7;

  localparam int A1 = 0;
  localparam int A2 = 1;
  localparam int A3 = 2;
  localparam int M1 = 3;
  localparam int M2 = 4;
  localparam int X1 = 5;
  localparam int X2 = 6;
  localparam int X3 = 7;

endpackage

// File: rtl/cycle_sequencer_decoder.sv
// Combinational decode of cycle index and sequencer state into the one-hot
// phase bus, the sync pulse and the frame-end marker.
module cycle_decoder
  import tb4004_pkg::*;
#(
  parameter int NUM_CYCLES = DEF_NUM_CYCLES,
  parameter int CW         = $clog2(NUM_CYCLES),
  parameter int SYNC_CYCLE = DEF_SYNC_CYCLE
) (
  input  logic [CW-1:0]         cycle,
  input  seq_state_e            state,
  output logic [NUM_CYCLES-1:0] phase,
  output logic                  sync,
  output logic                  frame_end
);

  logic running;

  assign running   = (state != ST_STOPPED);
  assign phase     = running ? (NUM_CYCLES'(1) << cycle) : '0;
  assign sync      = running && (cycle == CW'(SYNC_CYCLE));
  assign frame_end = running && (cycle == CW'(NUM_CYCLES - 1));

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction-cycle sequencer: frame counter, RUN/STEP/STOPPED control with
// halt and single-step at frame boundaries, and a retired-frame counter.
module cycle_sequencer
  import tb4004_pkg::*;
#(
  parameter int NUM_CYCLES   = DEF_NUM_CYCLES,
  parameter int CW           = $clog2(NUM_CYCLES),
  parameter int SYNC_CYCLE   = DEF_SYNC_CYCLE,
  parameter int ICNT_W       = 16,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                  toggle_clk,
  input  logic                  rst,
  input  logic                  halt_req,
  input  logic                  step,
  output logic [CW-1:0]         cycle,
  output logic [NUM_CYCLES-1:0] phase,
  output logic                  sync,
  output logic                  frame_end,
  output logic                  halted,
  output logic [ICNT_W-1:0]     instr_count
);

  generate
    if (NUM_CYCLES < 2) begin : g_bad_num_cycles
      $error("cycle_sequencer: NUM_CYCLES must be >= 2");
    end
    if (SYNC_CYCLE < 0 || SYNC_CYCLE > NUM_CYCLES - 1) begin : g_bad_sync_cycle
      $error("cycle_sequencer: SYNC_CYCLE must be in 0..NUM_CYCLES-1");
    end
    if (CW < $clog2(NUM_CYCLES) || CW < 1) begin : g_bad_cw
      $error("cycle_sequencer: CW too narrow for NUM_CYCLES");
    end
  endgenerate

  localparam logic [CW-1:0] LAST_CYCLE = CW'(NUM_CYCLES - 1);

  seq_state_e state;

  always_ff @(posedge toggle_clk) begin
    if (rst) begin
      cycle       <= '0;
      instr_count <= '0;
      state       <= START_HALTED ? ST_STOPPED : ST_RUN;
    end else begin
      case (state)
        ST_RUN, ST_STEP: begin
          if (cycle == LAST_CYCLE) begin
            cycle       <= '0;
            instr_count <= instr_count + ICNT_W'(1);
            // a step frame always ends stopped; a run frame only on halt_req
            if (state == ST_STEP || halt_req) state <= ST_STOPPED;
          end else begin
            cycle <= cycle + CW'(1);
          end
        end
        ST_STOPPED: begin
          cycle <= '0;
          if (!halt_req)  state <= ST_RUN;
          else if (step)  state <= ST_STEP;
        end
        default: begin
          cycle <= '0;
          state <= ST_STOPPED;
        end
      endcase
    end
  end

  assign halted = (state == ST_STOPPED);

  cycle_decoder #(
    .NUM_CYCLES(NUM_CYCLES),
    .CW        (CW),
    .SYNC_CYCLE(SYNC_CYCLE)
  ) u_decoder (
    .cycle    (cycle),
    .state    (state),
    .phase    (phase),
    .sync     (sync),
    .frame_end(frame_end)
  );

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer: two instances (run and start-halted
// reset) share stimulus; a frame-level model predicts every output per clock.
module tb_cycle_sequencer;

  localparam int N  = 8;
  localparam int SC = 7;
  localparam int IW = 4;

  logic toggle_clk = 1'b0;
  logic rst = 1'b1, halt_req = 1'b0, step = 1'b0;

  logic [2:0]    cyc0, cyc1;
  logic [N-1:0]  ph0, ph1;
  logic          sy0, sy1, fe0, fe1, hl0, hl1;
  logic [IW-1:0] ic0, ic1;

  cycle_sequencer #(.NUM_CYCLES(N), .SYNC_CYCLE(SC), .ICNT_W(IW), .START_HALTED(1'b0)) dut0 (
    .toggle_clk(toggle_clk), .rst(rst), .halt_req(halt_req), .step(step),
    .cycle(cyc0), .phase(ph0), .sync(sy0), .frame_end(fe0), .halted(hl0), .instr_count(ic0)
  );

  cycle_sequencer #(.NUM_CYCLES(N), .SYNC_CYCLE(SC), .ICNT_W(IW), .START_HALTED(1'b1)) dut1 (
    .toggle_clk(toggle_clk), .rst(rst), .halt_req(halt_req), .step(step),
    .cycle(cyc1), .phase(ph1), .sync(sy1), .frame_end(fe1), .halted(hl1), .instr_count(ic1)
  );

  always #5 toggle_clk = ~toggle_clk;

  // Frame-level model: position within the frame, whether the sequencer is
  // stopped, and whether the current frame is a one-shot step.
  typedef struct {
    bit stopped;
    bit one_shot;
    int pos;
    int frames;
  } mdl_t;

  typedef struct packed {
    logic [2:0]    cycle;
    logic [N-1:0]  phase;
    logic          sync;
    logic          fe;
    logic          halted;
    logic [IW-1:0] cnt;
  } obs_t;

  typedef struct {
    obs_t e0;
    obs_t e1;
  } exp_t;

  exp_t exp_q[$];
  mdl_t m0, m1;
  int   checks = 0;
  int   errors = 0;

  function automatic mdl_t mdl_next(mdl_t m, bit r, bit h, bit s, bit start_halted);
    mdl_t n = m;
    if (r) begin
      n.stopped  = start_halted;
      n.one_shot = 0;
      n.pos      = 0;
      n.frames   = 0;
    end else if (m.stopped) begin
      n.pos = 0;
      if (!h) begin
        n.stopped = 0; n.one_shot = 0;
      end else if (s) begin
        n.stopped = 0; n.one_shot = 1;
      end
    end else if (m.pos == N - 1) begin
      n.pos    = 0;
      n.frames = (m.frames + 1) % (1 << IW);
      if (m.one_shot || h) begin
        n.stopped = 1; n.one_shot = 0;
      end
    end else begin
      n.pos = m.pos + 1;
    end
    return n;
  endfunction

  function automatic obs_t mdl_out(mdl_t m);
    obs_t o;
    o.cycle  = 3'(m.pos);
    o.phase  = m.stopped ? '0 : N'(1 << m.pos);
    o.sync   = !m.stopped && (m.pos == SC);
    o.fe     = !m.stopped && (m.pos == N - 1);
    o.halted = m.stopped;
    o.cnt    = IW'(m.frames);
    return o;
  endfunction

  task automatic drive(input bit r, input bit h, input bit s);
    exp_t e;
    @(negedge toggle_clk);
    rst = r; halt_req = h; step = s;
    m0 = mdl_next(m0, r, h, s, 1'b0);
    m1 = mdl_next(m1, r, h, s, 1'b1);
    e.e0 = mdl_out(m0);
    e.e1 = mdl_out(m1);
    exp_q.push_back(e);
  endtask

  task automatic run_until_pos(input int p, input bit h);
    for (int i = 0; i < 4 * N && m0.pos != p; i++) drive(0, h, 0);
  endtask

  task automatic cmp(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got cycle=%0d phase=%b sync=%b fe=%b halted=%b cnt=%0d, expected cycle=%0d phase=%b sync=%b fe=%b halted=%b cnt=%0d",
               name, got.cycle, got.phase, got.sync, got.fe, got.halted, got.cnt,
               want.cycle, want.phase, want.sync, want.fe, want.halted, want.cnt);
    end
  endtask

  // Monitor: the sequencer presents a new output set after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge toggle_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("dut0_outputs", '{cyc0, ph0, sy0, fe0, hl0, ic0}, e.e0);
        cmp("dut1_outputs", '{cyc1, ph1, sy1, fe1, hl1, ic1}, e.e1);
      end
    end
  end

  initial begin
    bit h;
    int waited;
    m0 = '{0, 0, 0, 0};
    m1 = '{1, 0, 0, 0};

    // reset and free run
    drive(1, 0, 0);
    drive(1, 1, 1);
    for (int i = 0; i < 20; i++) drive(0, 0, 0);

    // halt requested mid-frame completes the frame, then holds
    run_until_pos(3, 0);
    for (int i = 0; i < 12; i++) drive(0, 1, 0);

    // single step, with a second ignored step pulse inside the frame
    drive(0, 1, 1);
    for (int i = 0; i < 12; i++) drive(0, 1, (i == 3));

    // step/resume collision: run wins
    drive(0, 0, 1);
    for (int i = 0; i < 3 * N; i++) drive(0, 0, 0);

    // counter wrap over 16 frames
    for (int i = 0; i < 16 * N + 2; i++) drive(0, 0, 0);

    // reset mid-frame
    run_until_pos(5, 0);
    drive(1, 0, 0);
    drive(0, 1, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0);

    // randomized halt levels, step pulses and rare resets
    h = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) h = ~h;
      drive(($urandom_range(0, 299) == 0), h, ($urandom_range(0, 5) == 0));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge toggle_clk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
